barrel_shift_pipe: RTL
======================

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width; SHALL be a power of two, at least 4.
REQ-002 Parameter: AMTW, default 8, shift-amount width; SHALL satisfy 2^AMTW > WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  AMTW  shift amount, unsigned.
REQ-009 in_mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 in_cin  input  1  carry-in, returned when the amount is zero.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_data  output  WIDTH  shifted or rotated result.
REQ-014 out_cout  output  1  shifter carry-out.

Function
REQ-015 Transfers SHALL occur only on edges where valid and ready are both high.
REQ-016 The datapath SHALL be two registered stages: stage A (captured request) and stage B (result); out_data, out_cout and out_valid SHALL come directly from stage-B registers.
REQ-017 Latency: a request accepted at edge k with no stall SHALL have out_valid high in the cycle after edge k+1; throughput SHALL be one result per cycle.
REQ-018 advB = !B_valid || out_ready; advA = !A_valid || advB; in_ready SHALL equal advA (combinational).
REQ-019 On a stall (out_valid && !out_ready), stage B SHALL hold, stage A SHALL hold if it is valid, and no request SHALL be lost or duplicated.
REQ-020 Simultaneous accept and drain in one cycle SHALL be supported with no bubble.
REQ-021 The result SHALL be computed combinationally between stage A and stage B as a log2(WIDTH)-level mux network; a multiply-based shift SHALL NOT be used.
REQ-022 Zero amount (any mode): out_data = in_data, out_cout = in_cin.
REQ-023 LSL, 1 <= amt < WIDTH: data << amt; cout = data[WIDTH-amt].
REQ-024 LSL, amt = WIDTH: result 0, cout = data[0]; amt > WIDTH: result 0, cout 0.
REQ-025 LSR, 1 <= amt < WIDTH: logical right shift; cout = data[amt-1].
REQ-026 LSR, amt = WIDTH: result 0, cout = data[WIDTH-1]; amt > WIDTH: result 0, cout 0.
REQ-027 ASR, 1 <= amt < WIDTH: sign-filling right shift; cout = data[amt-1].
REQ-028 ASR, amt >= WIDTH: every result bit and cout = data[WIDTH-1].
REQ-029 ROR: rotate right by amt mod WIDTH; cout = result[WIDTH-1] for nonzero amt.
REQ-030 ROR wrap-around: nonzero amt that is a multiple of WIDTH SHALL return data unchanged, with cout = data[WIDTH-1].
REQ-031 All amount comparisons SHALL use the full AMTW bits; upper bits SHALL NOT be truncated except by the ROR modulo.

Reset
REQ-032 While reset is high: A_valid and B_valid = 0, out_valid = 0, out_data = 0, out_cout = 0, in_ready = 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight requests asynchronously, with no output after release until new requests arrive.
REQ-034 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification (WIDTH=8, AMTW=8)
REQ-035 ROR sweep: in_data=F1h, amounts 0..15, cin=0 -> F1,F8,7C,3E,1F,8F,C7,E3, repeating; amt 8 gives F1 with cout 1.
REQ-036 Boundaries: LSL F1h by 8 -> 00 cout 1; LSR F1h by 9 -> 00 cout 0; ASR 81h by 3 -> F0 cout 0; ASR 81h by 200 -> FF cout 1.
REQ-037 Zero amount: LSR 5Ah by 0, cin=1 -> 5A cout 1; LSL A5h by 1 -> 4A cout 1.
REQ-038 Backpressure: stream 6 back-to-back requests with out_ready low for 4 cycles mid-stream -> in_ready drops after the pipe is full; all 6 results arrive in order, none duplicated.
REQ-039 Full rate: 16 consecutive requests with out_ready held high -> first out_valid 2 cycles after first accept, then one result per cycle.
REQ-040 Reset: assert reset with both stages valid -> out_valid 0 immediately; after release, out_valid stays 0 until a new request completes.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: two-stage valid/ready pipelined shifter/rotator
// with carry-in/carry-out (LSL, LSR, ASR, ROR).
module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [AMTW-1:0] W_AMT = AMTW'(WIDTH);

  typedef enum logic [1:0] {
    M_LSL = 2'b00,
    M_LSR = 2'b01,
    M_ASR = 2'b10,
    M_ROR = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AMTW-1:0]  amt;
    mode_e            mode;
    logic             cin;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             cout;
  } res_t;

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++) begin
      r[j] = v[WIDTH-1-j];
    end
    return r;
  endfunction

  logic a_valid;
  logic b_valid;
  logic adv_a;
  logic adv_b;
  req_t a_q;
  res_t b_q;
  res_t res;

  assign adv_b     = !b_valid || out_ready;
  assign adv_a     = !a_valid || adv_b;
  assign in_ready  = adv_a;
  assign out_valid = b_valid;
  assign out_data  = b_q.data;
  assign out_cout  = b_q.cout;

  logic is_lsl;
  logic is_asr;
  logic is_ror;
  logic sign;
  logic fill;
  logic amt_zero;
  logic amt_eq;
  logic amt_gt;
  logic amt_ge;
  logic [LW-1:0]    sh;
  logic [WIDTH-1:0] src;
  logic [WIDTH:0]   net;
  logic [WIDTH-1:0] net_data;

  assign is_lsl   = a_q.mode == M_LSL;
  assign is_asr   = a_q.mode == M_ASR;
  assign is_ror   = a_q.mode == M_ROR;
  assign sign     = a_q.data[WIDTH-1];
  assign fill     = is_asr && sign;
  assign amt_zero = a_q.amt == '0;
  assign amt_eq   = a_q.amt == W_AMT;
  assign amt_gt   = a_q.amt > W_AMT;
  assign amt_ge   = amt_eq || amt_gt;
  assign sh       = a_q.amt[LW-1:0];

  // LSL runs through the right-shift network bit-reversed; the extra
  // low bit carries cin in and collects the last bit shifted out.
  assign src = is_lsl ? rev(a_q.data) : a_q.data;

  for (genvar i = 0; i < LW; i++) begin : g_lvl
    localparam int K = 1 << i;
    logic [WIDTH:0] prv;
    logic [WIDTH:0] nxt;
    logic [K-1:0]   top;
    if (i == 0) begin : g_first
      assign prv = {src, a_q.cin};
    end else begin : g_rest
      assign prv = g_lvl[i-1].nxt;
    end
    assign top = is_ror ? prv[K:1] : {K{fill}};
    assign nxt = sh[i] ? {top, prv[WIDTH:K]} : prv;
  end

  assign net      = g_lvl[LW-1].nxt;
  assign net_data = is_lsl ? rev(net[WIDTH:1])
                           : net[WIDTH:1];

  logic ror_nz;
  logic asr_big;
  logic lin_eq;
  logic lin_gt;

  assign ror_nz  = is_ror && !amt_zero;
  assign asr_big = is_asr && amt_ge;
  assign lin_eq  = !is_ror && !is_asr && amt_eq;
  assign lin_gt  = !is_ror && !is_asr && amt_gt;

  always_comb begin
    res.data = net_data;
    res.cout = net[0];
    unique case (1'b1)
      amt_zero: begin
        res.data = a_q.data;
        res.cout = a_q.cin;
      end
      ror_nz: begin
        res.cout = net_data[WIDTH-1];
      end
      asr_big: begin
        res.data = {WIDTH{sign}};
        res.cout = sign;
      end
      lin_eq: begin
        res.data = '0;
        res.cout = is_lsl ? a_q.data[0] : sign;
      end
      lin_gt: begin
        res.data = '0;
        res.cout = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (adv_a) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_q <= '{data: in_data,
                 amt:  in_amt,
                 mode: mode_e'(in_mode),
                 cin:  in_cin};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_q <= res;
      end
    end
  end

endmodule
